// File: rtl/tdm_demux_pkg.sv
// Shared constants and state encoding for the 1-to-4 TDM demultiplexer.
package tdm_demux_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;
endpackage

// File: rtl/demux_slot_decoder.sv
// One-hot decode of a slot index into shadow write enables, gated by a strobe.
module demux_slot_decoder
    import tdm_demux_pkg::*;
(
    input  logic [SLOT_W-1:0]    slot,
    input  logic                 strobe,
    output logic [NUM_SLOTS-1:0] we
);
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_dec
        assign we[gi] = strobe && (slot == SLOT_W'(gi));
    end
endmodule

// File: rtl/tdm_one_cross_four_demux.sv
// Collects four framed beats into a hidden shadow and publishes them to the
// channel outputs atomically once per complete frame.
module tdm_one_cross_four_demux
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic              in_valid,
    input  logic              sync,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              err
);
    state_t                state_reg;
    logic [SLOT_W-1:0]     slot_reg;
    logic                  frame_valid_reg;
    logic                  err_reg;
    logic [WIDTH-1:0]      shadow_reg [NUM_SLOTS];
    logic [WIDTH-1:0]      out_reg    [NUM_SLOTS];

    logic                  accept;
    logic                  short_frame;
    logic                  complete;
    logic                  wr_strobe;
    logic [SLOT_W-1:0]     wr_slot;
    logic [NUM_SLOTS-1:0]  shadow_we;

    assign accept      = in_valid;
    assign short_frame = accept && sync && (state_reg == COLLECT);
    assign complete    = accept && !sync && (state_reg == COLLECT)
                         && (slot_reg == SLOT_W'(NUM_SLOTS - 1));
    // A sync beat always restarts at slot 0; non-sync beats in IDLE are dropped.
    assign wr_strobe   = accept && (sync || (state_reg == COLLECT));
    assign wr_slot     = sync ? '0 : slot_reg;

    demux_slot_decoder u_dec (
        .slot   (wr_slot),
        .strobe (wr_strobe),
        .we     (shadow_we)
    );

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_shadow
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_reg[gi] <= '0;
            end else if (shadow_we[gi]) begin
                shadow_reg[gi] <= in;
            end else if (short_frame) begin
                shadow_reg[gi] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            slot_reg        <= '0;
            frame_valid_reg <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) out_reg[i] <= '0;
        end else begin
            frame_valid_reg <= 1'b0;
            if (accept) begin
                case (state_reg)
                    IDLE: begin
                        if (sync) begin
                            slot_reg  <= SLOT_W'(1);
                            state_reg <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (sync) begin
                            slot_reg <= SLOT_W'(1);
                        end else if (complete) begin
                            // The last beat bypasses the shadow so the frame lands in one edge.
                            for (int i = 0; i < NUM_SLOTS - 1; i++) out_reg[i] <= shadow_reg[i];
                            out_reg[NUM_SLOTS-1] <= in;
                            frame_valid_reg      <= 1'b1;
                            slot_reg             <= '0;
                            state_reg            <= IDLE;
                        end else begin
                            slot_reg <= slot_reg + SLOT_W'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (short_frame) begin
            err_reg <= 1'b1;
        end else if (err_clr) begin
            err_reg <= 1'b0;
        end
    end

    assign out0        = out_reg[0];
    assign out1        = out_reg[1];
    assign out2        = out_reg[2];
    assign out3        = out_reg[3];
    assign frame_valid = frame_valid_reg;
    assign slot        = slot_reg;
    assign err         = err_reg;
endmodule
